// File: rtl/serial_fifo_ctrl_pkg.sv
// Shared definitions for serial_fifo_ctrl: register offsets, STATUS/CTRL bit positions
// and the TX drain FSM state encoding.
package serial_fifo_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  localparam int ST_TX_NFULL  = 0;
  localparam int ST_RX_NEMPTY = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_TX_OVF    = 4;

  localparam int CT_RX_IE     = 0;
  localparam int CT_TX_IE     = 1;
  localparam int CT_OVF_IE    = 2;
  localparam int CT_FLUSH_RX  = 3;
  localparam int CT_FLUSH_TX  = 4;
  localparam int CT_LOOPBACK  = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_HOLD  = 2'd2,
    TX_DRAIN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, flush and occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      din_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// Buffered COM controller: RX/TX FIFOs, TX drain FSM, sticky overflows, maskable interrupt.
// Optional macro SERIAL_LOOPBACK_EN adds CTRL[5] internal TX->RX loopback.
module serial_fifo_ctrl
  import serial_fifo_ctrl_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_INT_LEVEL  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam logic [RX_DEPTH_LOG2:0] RX_LVL = (RX_DEPTH_LOG2+1)'(RX_INT_LEVEL);

  logic rd_acc, wr_acc;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [7:0] rx_din, rx_head, tx_head;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic rx_ovf_set, tx_ovf_set, tx_idle, lb_on, lb_push;

  tx_state_e   state_q, state_d;
  logic [7:0]  txd_data_q, txd_data_d;
  logic [2:0]  ie_q, ie_d;
  logic        rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, int_q, int_d;

  logic unused_ok;
  assign unused_ok = ^dataSave_i[31:5];

  assign rd_acc = enable_i & readEnable_i;
  assign wr_acc = enable_i & ~readEnable_i;

`ifdef SERIAL_LOOPBACK_EN
  logic lb_q, lb_d;
  assign lb_d = (wr_acc && addr_i == ADDR_CTRL) ? dataSave_i[CT_LOOPBACK] : lb_q;
  always_ff @(posedge clk) begin
    if (rst) lb_q <= 1'b0;
    else     lb_q <= lb_d;
  end
  assign lb_on = lb_q;
`else
  assign lb_on = 1'b0;
`endif

  // Loopback replaces the external receiver as the RX source.
  assign rx_push  = lb_on ? lb_push : rxdReady_i;
  assign rx_din   = lb_on ? txd_data_q : rxdData_i;
  assign rx_pop   = rd_acc & (addr_i == ADDR_DATA) & ~rx_empty;
  assign rx_flush = wr_acc & (addr_i == ADDR_CTRL) & dataSave_i[CT_FLUSH_RX];
  assign tx_push  = wr_acc & (addr_i == ADDR_DATA) & ~tx_full;
  assign tx_flush = wr_acc & (addr_i == ADDR_CTRL) & dataSave_i[CT_FLUSH_TX];

  assign rx_ovf_set = rx_push & rx_full & ~rx_pop & ~rx_flush;
  assign tx_ovf_set = wr_acc & (addr_i == ADDR_DATA) & tx_full;
  assign tx_idle    = tx_empty & (state_q == TX_IDLE);

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .flush_i(rx_flush),
    .din_i(rx_din), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .flush_i(tx_flush),
    .din_i(dataSave_i[7:0]), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  // TX drain FSM; HOLD covers the transmitter's busy-rise latency.
  always_comb begin
    state_d    = state_q;
    txd_data_d = txd_data_q;
    tx_pop     = 1'b0;
    txdStart_o = 1'b0;
    lb_push    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !txdBusy_i) begin
          state_d    = TX_START;
          txd_data_d = tx_head;
        end
      end
      TX_START: begin
        tx_pop = 1'b1;
        if (lb_on) begin
          lb_push = 1'b1;
          state_d = TX_IDLE;
        end else begin
          txdStart_o = 1'b1;
          state_d    = TX_HOLD;
        end
      end
      TX_HOLD:  state_d = TX_DRAIN;
      TX_DRAIN: if (!txdBusy_i) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    ie_d     = ie_q;
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (wr_acc && addr_i == ADDR_CTRL) ie_d = dataSave_i[2:0];
    if (wr_acc && addr_i == ADDR_STATUS) begin
      if (dataSave_i[ST_RX_OVF]) rx_ovf_d = 1'b0;
      if (dataSave_i[ST_TX_OVF]) tx_ovf_d = 1'b0;
    end
    if (rx_ovf_set) rx_ovf_d = 1'b1;
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    int_d = (ie_q[CT_RX_IE]  & (rx_count >= RX_LVL))
          | (ie_q[CT_TX_IE]  & tx_idle)
          | (ie_q[CT_OVF_IE] & (rx_ovf_q | tx_ovf_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      txd_data_q <= '0;
      ie_q       <= '0;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_data_q <= txd_data_d;
      ie_q       <= ie_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
      int_q      <= int_d;
    end
  end

  assign int_o     = int_q;
  assign txdData_o = txd_data_q;

  always_comb begin
    dataLoad_o = '0;
    case (addr_i)
      ADDR_DATA:   dataLoad_o[7:0] = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: begin
        dataLoad_o[ST_TX_NFULL]  = ~tx_full;
        dataLoad_o[ST_RX_NEMPTY] = ~rx_empty;
        dataLoad_o[ST_TX_IDLE]   = tx_idle;
        dataLoad_o[ST_RX_OVF]    = rx_ovf_q;
        dataLoad_o[ST_TX_OVF]    = tx_ovf_q;
      end
      ADDR_CTRL: begin
        dataLoad_o[2:0]         = ie_q;
        dataLoad_o[CT_LOOPBACK] = lb_on;
      end
      default: begin
        dataLoad_o[15:8] = 8'(tx_count);
        dataLoad_o[7:0]  = 8'(rx_count);
      end
    endcase
  end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Scoreboard bench for serial_fifo_ctrl: RX/TX byte queues checked as the DUT emits data.
module tb_serial_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        readEnable_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] dataSave_i = '0;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = '0;
  logic        txdBusy_i;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  logic        busy_force = 1'b0;
  logic        busy_model = 1'b0;
  int          busy_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  assign txdBusy_i = busy_force | busy_model;

  always #5 clk = ~clk;

  serial_fifo_ctrl dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
    .addr_i(addr_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o), .int_o(int_o),
    .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i), .txdBusy_i(txdBusy_i),
    .txdStart_o(txdStart_o), .txdData_o(txdData_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%0h", tag, got);
    end
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b1; addr_i = a;
    #1 d = dataLoad_o;
    @(negedge clk);
    enable_i = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b0; addr_i = a; dataSave_i = v;
    @(negedge clk);
    enable_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rxdReady_i = 1'b1; rxdData_i = b;
    @(negedge clk);
    rxdReady_i = 1'b0;
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = 0;
    if (rx_exp_q.size() != 0) exp = {24'h0, rx_exp_q.pop_front()};
    reg_read(2'd0, d);
    check_val(tag, d, exp);
  endtask

  // Transmit monitor plus busy model: busy follows each start for 10 cycles.
  always @(negedge clk) begin
    if (txdStart_o) begin
      check_val("tx_start_not_busy", {31'h0, busy_model}, 32'h0);
      if (tx_exp_q.size() == 0) check_val("tx_start_unexpected", {24'h0, txdData_o}, 32'hFFFF_FFFF);
      else check_val("tx_byte", {24'h0, txdData_o}, {24'h0, tx_exp_q.pop_front()});
      busy_cnt   <= 10;
      busy_model <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt   <= 0;
      busy_model <= 1'b0;
    end
  end

  initial begin
    logic [31:0] d;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    reg_read(2'd1, d); check_val("reset_status", d, 32'h5);
    reg_read(2'd3, d); check_val("reset_level", d, 32'h0);
    check_val("reset_int", {31'h0, int_o}, 32'h0);
    check_val("reset_txstart", {31'h0, txdStart_o}, 32'h0);

    // Basic RX ordering
    for (int i = 0; i < 3; i++) begin
      rx_pulse(8'h41 + 8'(i));
      rx_exp_q.push_back(8'h41 + 8'(i));
    end
    for (int i = 0; i < 3; i++) rx_read("rx_data");
    rx_read("rx_empty_read");
    reg_read(2'd1, d); check_val("rx_empty_status1", {31'h0, d[1]}, 32'h0);

    // RX overflow, push+pop when full, flush
    for (int i = 0; i < 17; i++) begin
      rx_pulse(8'h10 + 8'(i));
      if (i < 16) rx_exp_q.push_back(8'h10 + 8'(i));
    end
    reg_read(2'd1, d); check_val("rx_ovf_status", d, 32'hF);
    reg_read(2'd3, d); check_val("rx_full_level", d, 32'h10);
    @(negedge clk);
    enable_i = 1'b1; readEnable_i = 1'b1; addr_i = 2'd0;
    rxdReady_i = 1'b1; rxdData_i = 8'h99;
    #1 check_val("rx_full_pushpop", dataLoad_o, {24'h0, rx_exp_q.pop_front()});
    rx_exp_q.push_back(8'h99);
    @(negedge clk);
    enable_i = 1'b0; rxdReady_i = 1'b0;
    reg_read(2'd3, d); check_val("rx_pushpop_level", d, 32'h10);
    reg_read(2'd1, d); check_val("rx_pushpop_noovf_extra", {31'h0, d[3]}, 32'h1);
    rx_read("rx_after_pushpop");
    reg_write(2'd2, 32'h08);
    rx_exp_q.delete();
    reg_read(2'd3, d); check_val("rx_flush_level", d, 32'h0);
    reg_read(2'd2, d); check_val("ctrl_flush_reads0", d, 32'h0);
    reg_write(2'd1, 32'h08);
    reg_read(2'd1, d); check_val("rx_ovf_cleared", d, 32'h5);

    // TX fill while busy, overflow, then drain
    busy_force = 1'b1;
    for (int i = 0; i < 17; i++) begin
      reg_write(2'd0, 32'hA0 + 32'(i));
      if (i < 16) tx_exp_q.push_back(8'hA0 + 8'(i));
    end
    reg_read(2'd3, d); check_val("tx_full_level", d, 32'h1000);
    reg_read(2'd1, d); check_val("tx_ovf_status", d, 32'h10);
    reg_write(2'd1, 32'h10);
    reg_read(2'd1, d); check_val("tx_ovf_cleared", d, 32'h0);
    @(negedge clk);
    busy_force = 1'b0;
    n = 0;
    while (tx_exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_drain_done", tx_exp_q.size(), 0);
    n = 0;
    d = 0;
    while (d[2] == 1'b0 && n < 50) begin
      reg_read(2'd1, d);
      n++;
    end
    check_val("tx_idle_status", d, 32'h5);
    reg_read(2'd3, d); check_val("tx_drained_level", d, 32'h0);

    // RX interrupt latency
    reg_write(2'd2, 32'h1);
    rx_pulse(8'h77);
    rx_exp_q.push_back(8'h77);
    check_val("int_not_yet", {31'h0, int_o}, 32'h0);
    @(negedge clk);
    check_val("int_rise", {31'h0, int_o}, 32'h1);
    rx_read("int_rx_data");
    check_val("int_still_high", {31'h0, int_o}, 32'h1);
    @(negedge clk);
    check_val("int_fall", {31'h0, int_o}, 32'h0);

`ifdef SERIAL_LOOPBACK_EN
    reg_write(2'd2, 32'h20);
    reg_read(2'd2, d); check_val("ctrl_loopback", d, 32'h20);
    reg_write(2'd0, 32'h5A);
    rx_exp_q.push_back(8'h5A);
    repeat (10) @(negedge clk);
    rx_read("loopback_data");
`else
    reg_write(2'd2, 32'h27);
    reg_read(2'd2, d); check_val("ctrl_rw_no_lb", d, 32'h7);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
